score_record_manager: RTL and testbench

Sequential owner of the per-user, per-song learning-score records. It captures a finished learning run's score into a 4-user by 3-song record file and serves a combinational read port for the display path. On request it computes a user's three-song average with a serial divide-by-3. It sits between the learning-mode datapath and the main display selector, replacing ad-hoc combinational record writes and the combinational divider.

---
 rtl/score_record_manager_pkg.sv | 29 ++
 rtl/score_record_manager_div3.sv | 86 ++++++++
 rtl/score_record_manager.sv | 169 ++++++++++++++++
 tb/tb_score_record_manager.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_record_manager_pkg.sv
// Shared definitions for the score record manager: widths, FSM encoding and
// the record-file index helper.
package score_record_manager_pkg;

  // Default width of one stored score.
  localparam int SRM_SCORE_W = 41;

  // Record file geometry: 4 users x 3 storable songs.
  localparam int SRM_USERS = 4;
  localparam int SRM_SONGS = 3;
  localparam int SRM_RECS  = SRM_USERS * SRM_SONGS;

  // Song index 2'b11 is the summary view and is never stored.
  localparam logic [1:0] SRM_SUMMARY_SONG = 2'b11;

  typedef enum logic [2:0] {
    SRM_IDLE  = 3'd0,
    SRM_WRITE = 3'd1,
    SRM_SUM   = 3'd2,
    SRM_DIV   = 3'd3,
    SRM_DONE  = 3'd4
  } srm_state_e;

  // Flat record index user*3 + song; only meaningful for song < 3.
  function automatic logic [3:0] rec_idx(input logic [1:0] user, input logic [1:0] song);
    return {1'b0, user, 1'b0} + {2'b00, user} + {2'b00, song};
  endfunction

endpackage

// File: rtl/score_record_manager_div3.sv
// Serial restoring divide-by-3. One quotient bit per cycle, MSB first.
// The dividend is known to be below 3 * 2^QUO_W, so only the low QUO_W
// quotient bits can be non-zero and only those are kept.
module serial_div3
  import score_record_manager_pkg::*;
#(
  parameter int DVD_W = SRM_SCORE_W + 2,
  parameter int QUO_W = SRM_SCORE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [QUO_W-1:0] quotient_o
);

  localparam int CW = $clog2(DVD_W);

  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [QUO_W-2:0] quo_q, quo_d;
  logic [1:0]       rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Trial step: remainder shifted left with the next dividend bit (3 bits of headroom).
  logic [2:0] trial;
  logic       q_bit;
  logic [1:0] rem_next;

  // Compute the current quotient bit and the next remainder.
  always_comb begin
    trial    = {rem_q, dvd_q[DVD_W-1]};
    q_bit    = (trial >= 3'd3);
    rem_next = q_bit ? 2'(trial - 3'd3) : trial[1:0];
  end

  // Next-state logic: load on start, otherwise shift one bit per busy cycle.
  always_comb begin
    dvd_d  = dvd_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      dvd_d  = dividend_i;
      quo_d  = '0;
      rem_d  = '0;
      cnt_d  = CW'(DVD_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
      quo_d = quotient_o[QUO_W-2:0];
      rem_d = rem_next;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // The final bit is produced combinationally so the full quotient is
  // available in the same cycle as done_o.
  assign quotient_o = {quo_q, q_bit};
  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == '0);

endmodule

// File: rtl/score_record_manager.sv
// Owner of the 4-user x 3-song score records: captures finished learning
// runs, serves a combinational read port and computes per-user averages.
module score_record_manager
  import score_record_manager_pkg::*;
#(
  parameter int SCORE_W   = SRM_SCORE_W,
  parameter int KEEP_BEST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fin,
  input  logic [1:0]         wr_user,
  input  logic [1:0]         wr_song,
  input  logic [SCORE_W-1:0] wr_score,
  input  logic [1:0]         rd_user,
  input  logic [1:0]         rd_song,
  output logic [SCORE_W-1:0] rd_score,
  input  logic               avg_req,
  input  logic [1:0]         avg_user,
  output logic               busy,
  output logic               avg_valid,
  output logic [SCORE_W-1:0] avg_score,
  output logic               wr_done
);

  localparam int SUM_W = SCORE_W + 2;

  srm_state_e state_q, state_d;

  logic               fin_q;
  logic               pend_q;
  logic [1:0]         lat_user_q;
  logic [1:0]         lat_song_q;
  logic [SCORE_W-1:0] lat_score_q;
  logic [1:0]         avg_user_q, avg_user_d;
  logic [SCORE_W-1:0] avg_score_q, avg_score_d;
  logic               wr_done_q;

  logic [SCORE_W-1:0] rec_q [SRM_RECS];

  logic               fin_rise;
  logic               rec_we;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [SCORE_W-1:0] div_quot;
  logic [SUM_W-1:0]   sum_w;
  logic [3:0]         wr_idx, rd_idx;

  assign fin_rise = fin && !fin_q;

  // Song 3 never addresses a record; clamp so the index stays in range.
  assign wr_idx = (lat_song_q == SRM_SUMMARY_SONG) ? 4'd0 : rec_idx(lat_user_q, lat_song_q);
  assign rd_idx = (rd_song == SRM_SUMMARY_SONG) ? 4'd0 : rec_idx(rd_user, rd_song);

  assign sum_w = {2'b00, rec_q[rec_idx(avg_user_q, 2'd0)]}
               + {2'b00, rec_q[rec_idx(avg_user_q, 2'd1)]}
               + {2'b00, rec_q[rec_idx(avg_user_q, 2'd2)]};

  // Edge detect on fin and latch the run; a new rise wins over the clear in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q       <= 1'b0;
      pend_q      <= 1'b0;
      lat_user_q  <= '0;
      lat_song_q  <= '0;
      lat_score_q <= '0;
    end else begin
      fin_q <= fin;
      if (fin_rise) begin
        pend_q      <= 1'b1;
        lat_user_q  <= wr_user;
        lat_song_q  <= wr_song;
        lat_score_q <= wr_score;
      end else if (state_q == SRM_WRITE) begin
        pend_q <= 1'b0;
      end
    end
  end

  // FSM next state, record write enable and divider start.
  always_comb begin
    state_d     = state_q;
    avg_user_d  = avg_user_q;
    avg_score_d = avg_score_q;
    rec_we      = 1'b0;
    div_start   = 1'b0;
    case (state_q)
      SRM_IDLE: begin
        if (pend_q) begin
          state_d = SRM_WRITE;
        end else if (avg_req) begin
          avg_user_d = avg_user;
          state_d    = SRM_SUM;
        end
      end
      SRM_WRITE: begin
        rec_we  = (lat_song_q != SRM_SUMMARY_SONG)
               && ((KEEP_BEST == 0) || (lat_score_q > rec_q[wr_idx]));
        state_d = SRM_IDLE;
      end
      SRM_SUM: begin
        div_start = 1'b1;
        state_d   = SRM_DIV;
      end
      SRM_DIV: begin
        if (div_done) begin
          avg_score_d = div_quot;
          state_d     = SRM_DONE;
        end else if (!div_busy) begin
          // Divider lost its job; recover rather than hang.
          state_d = SRM_IDLE;
        end
      end
      SRM_DONE: begin
        // A write that arrived during the average is serviced immediately.
        state_d = pend_q ? SRM_WRITE : SRM_IDLE;
      end
      default: state_d = SRM_IDLE;
    endcase
  end

  // FSM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SRM_IDLE;
      avg_user_q  <= '0;
      avg_score_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      avg_user_q  <= avg_user_d;
      avg_score_q <= avg_score_d;
      wr_done_q   <= (state_q == SRM_WRITE);
    end
  end

  // Record file: one register per storable {user, song} entry.
  for (genvar gi = 0; gi < SRM_RECS; gi++) begin : g_rec
    // Commit the latched score into this entry when it is addressed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rec_q[gi] <= '0;
      end else if (rec_we && (wr_idx == 4'(gi))) begin
        rec_q[gi] <= lat_score_q;
      end
    end
  end

  serial_div3 #(
    .DVD_W (SUM_W),
    .QUO_W (SCORE_W)
  ) u_div3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (sum_w),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  assign rd_score  = (rd_song == SRM_SUMMARY_SONG) ? '0 : rec_q[rd_idx];
  assign busy      = (state_q != SRM_IDLE);
  assign avg_valid = (state_q == SRM_DONE);
  assign avg_score = avg_score_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_score_record_manager.sv
// Bench for score_record_manager: one overwrite instance and one keep-best
// instance share all inputs and are checked against a record model.
module tb_score_record_manager;

  localparam int W = 41;
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fin;
  logic [1:0]   wr_user, wr_song, rd_user, rd_song, avg_user;
  logic [W-1:0] wr_score;
  logic         avg_req;

  logic [W-1:0] rd_score0, rd_score1, avg_score0, avg_score1;
  logic         busy0, busy1, avg_valid0, avg_valid1, wr_done0, wr_done1;

  always #5 clk = ~clk;

  score_record_manager #(.SCORE_W(W), .KEEP_BEST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fin(fin), .wr_user(wr_user), .wr_song(wr_song),
    .wr_score(wr_score), .rd_user(rd_user), .rd_song(rd_song), .rd_score(rd_score0),
    .avg_req(avg_req), .avg_user(avg_user), .busy(busy0), .avg_valid(avg_valid0),
    .avg_score(avg_score0), .wr_done(wr_done0)
  );

  score_record_manager #(.SCORE_W(W), .KEEP_BEST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fin(fin), .wr_user(wr_user), .wr_song(wr_song),
    .wr_score(wr_score), .rd_user(rd_user), .rd_song(rd_song), .rd_score(rd_score1),
    .avg_req(avg_req), .avg_user(avg_user), .busy(busy1), .avg_valid(avg_valid1),
    .avg_score(avg_score1), .wr_done(wr_done1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Record models: m0 always overwrites, m1 keeps the best score.
  logic [W-1:0] m0 [4][3];
  logic [W-1:0] m1 [4][3];

  typedef struct {
    logic [W-1:0] e0;
    logic [W-1:0] e1;
  } avg_exp_t;
  avg_exp_t sb_q[$];

  typedef struct {
    logic [1:0]   user;
    logic [1:0]   song;
    logic [W-1:0] score;
    logic [W-1:0] exp0;
    logic [W-1:0] exp1;
  } wr_vec_t;
  wr_vec_t vec [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 4; u++)
      for (int s = 0; s < 3; s++) begin
        m0[u][s] = '0;
        m1[u][s] = '0;
      end
  endtask

  task automatic model_write(input int u, input int s, input logic [W-1:0] sc);
    if (s != 3) begin
      m0[u][s] = sc;
      if (sc > m1[u][s]) m1[u][s] = sc;
    end
  endtask

  task automatic read_chk(input int u, input int s, input string tag);
    logic [W-1:0] e0, e1;
    rd_user = 2'(u);
    rd_song = 2'(s);
    #1;
    e0 = (s == 3) ? '0 : m0[u][s];
    e1 = (s == 3) ? '0 : m1[u][s];
    chk($sformatf("%s_rd0_u%0d_s%0d", tag, u, s), 64'(rd_score0), 64'(e0));
    chk($sformatf("%s_rd1_u%0d_s%0d", tag, u, s), 64'(rd_score1), 64'(e1));
  endtask

  task automatic scan_all(input string tag);
    for (int u = 0; u < 4; u++)
      for (int s = 0; s < 3; s++)
        read_chk(u, s, tag);
  endtask

  // One-cycle fin pulse; returns the negedge count at which wr_done appeared (0 = timeout).
  task automatic do_write(input int u, input int s, input logic [W-1:0] sc, output int lat);
    @(negedge clk);
    fin = 1'b1; wr_user = 2'(u); wr_song = 2'(s); wr_score = sc;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) fin = 1'b0;
      if (wr_done0) begin
        lat = i;
        break;
      end
    end
    chk("wr_done1_with_wr_done0", 64'(wr_done1), 64'(1));
    model_write(u, s, sc);
    $display("write u=%0d s=%0d score=%0d wr_done_latency=%0d", u, s, sc, lat);
  endtask

  // Average request; optionally injects a write (1,0,99) mid-division.
  task automatic run_avg(input int u, input bit mid_write);
    logic [W+1:0] s0, s1;
    avg_exp_t e, got;
    int lat, gap;
    s0 = {2'b00, m0[u][0]} + {2'b00, m0[u][1]} + {2'b00, m0[u][2]};
    s1 = {2'b00, m1[u][0]} + {2'b00, m1[u][1]} + {2'b00, m1[u][2]};
    e.e0 = W'(s0 / 3);
    e.e1 = W'(s1 / 3);
    sb_q.push_back(e);
    @(negedge clk);
    avg_req = 1'b1; avg_user = 2'(u);
    @(negedge clk);
    avg_req = 1'b0;
    chk("busy_after_avg_req", 64'(busy0), 64'(1));
    lat = 0;
    for (int i = 2; i <= 100; i++) begin
      if (mid_write && i == 12) begin
        fin = 1'b1; wr_user = 2'd1; wr_song = 2'd0; wr_score = W'(99);
      end
      if (mid_write && i == 13) fin = 1'b0;
      @(negedge clk);
      if (avg_valid0) begin
        lat = i;
        break;
      end
    end
    got = sb_q.pop_front();
    chk("avg_latency", 64'(lat), 64'(45));
    chk("avg_valid1", 64'(avg_valid1), 64'(1));
    chk("avg_score0", 64'(avg_score0), 64'(got.e0));
    chk("avg_score1", 64'(avg_score1), 64'(got.e1));
    $display("average u=%0d latency=%0d score0=%0d score1=%0d", u, lat, avg_score0, avg_score1);
    if (mid_write) begin
      gap = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (wr_done0) begin
          gap = i;
          break;
        end
      end
      chk("wr_done_after_avg_valid", 64'(gap), 64'(2));
      model_write(1, 0, W'(99));
      $display("write u=1 s=0 score=99 serviced %0d cycles after avg_valid", gap);
    end else begin
      @(negedge clk);
      chk("avg_valid_one_cycle", 64'(avg_valid0), 64'(0));
    end
  endtask

  initial begin
    int lat, cnt_wd, cnt_av;
    rst_n = 1'b0; fin = 1'b0; avg_req = 1'b0;
    wr_user = '0; wr_song = '0; wr_score = '0;
    rd_user = '0; rd_song = '0; avg_user = '0;
    model_clear();

    vec[0] = '{2'd2, 2'd1, W'(1000), W'(1000), W'(1000)};
    vec[1] = '{2'd1, 2'd0, W'(10),   W'(10),   W'(10)};
    vec[2] = '{2'd1, 2'd1, W'(20),   W'(20),   W'(20)};
    vec[3] = '{2'd1, 2'd2, W'(31),   W'(31),   W'(31)};
    vec[4] = '{2'd0, 2'd2, W'(500),  W'(500),  W'(500)};
    vec[5] = '{2'd0, 2'd2, W'(300),  W'(300),  W'(500)};
    vec[6] = '{2'd3, 2'd3, W'(777),  W'(0),    W'(0)};
    vec[7] = '{2'd3, 2'd0, W'(5),    W'(5),    W'(5)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy0), 64'(0));
    chk("reset_avg_score", 64'(avg_score0), 64'(0));
    chk("reset_avg_valid", 64'(avg_valid0), 64'(0));
    chk("reset_wr_done", 64'(wr_done0), 64'(0));
    rst_n = 1'b1;
    scan_all("reset");

    // Table-driven writes
    for (int k = 0; k < 8; k++) begin
      do_write(int'(vec[k].user), int'(vec[k].song), vec[k].score, lat);
      chk($sformatf("vec%0d_wr_latency", k), 64'(lat), 64'(3));
      rd_user = vec[k].user;
      rd_song = vec[k].song;
      #1;
      chk($sformatf("vec%0d_rd0", k), 64'(rd_score0), 64'(vec[k].exp0));
      chk($sformatf("vec%0d_rd1", k), 64'(rd_score1), 64'(vec[k].exp1));
    end
    scan_all("after_table");

    // fin held high: exactly one write
    @(negedge clk);
    fin = 1'b1; wr_user = 2'd3; wr_song = 2'd1; wr_score = W'(42);
    cnt_wd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 50) fin = 1'b0;
      if (wr_done0) cnt_wd++;
    end
    chk("fin_held_wr_done_count", 64'(cnt_wd), 64'(1));
    model_write(3, 1, W'(42));
    $display("write u=3 s=1 score=42 fin held 50 cycles, wr_done pulses=%0d", cnt_wd);
    read_chk(3, 1, "fin_held");

    // Averages
    run_avg(1, 1'b0);
    run_avg(0, 1'b0);
    run_avg(3, 1'b0);
    for (int s = 0; s < 3; s++) begin
      do_write(1, s, MAXV, lat);
      chk("max_wr_latency", 64'(lat), 64'(3));
    end
    run_avg(1, 1'b0);

    // Write arriving mid-division
    run_avg(1, 1'b1);
    read_chk(1, 0, "mid_div");

    // Reset in the middle of a division, with a write pending
    @(negedge clk);
    avg_req = 1'b1; avg_user = 2'd1;
    @(negedge clk);
    avg_req = 1'b0;
    repeat (20) @(negedge clk);
    fin = 1'b1; wr_user = 2'd2; wr_song = 2'd2; wr_score = W'(7);
    @(negedge clk);
    fin = 1'b0;
    rst_n = 1'b0;
    model_clear();
    cnt_av = 0; cnt_wd = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (avg_valid0 || avg_valid1) cnt_av++;
      if (wr_done0 || wr_done1) cnt_wd++;
    end
    chk("rst_mid_div_avg_valid", 64'(cnt_av), 64'(0));
    chk("rst_mid_div_wr_done", 64'(cnt_wd), 64'(0));
    chk("rst_mid_div_busy", 64'(busy0), 64'(0));
    chk("rst_mid_div_avg_score", 64'(avg_score0), 64'(0));
    $display("reset mid-division: avg_valid pulses=%0d wr_done pulses=%0d", cnt_av, cnt_wd);
    scan_all("after_rst");

    // Normal operation resumes after the abort
    do_write(0, 0, W'(9), lat);
    chk("post_rst_wr_latency", 64'(lat), 64'(3));
    run_avg(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
